regfile_sb: RTL and testbench

Parametrised general-purpose register file for the pipelined CPU core, generalising the fixed 32x32, 2-read/1-write file.
- Configurable data width, depth and read-port count.
- Optional write-to-read bypass and optional hardwired zero register.
- Per-register busy scoreboard, set at issue and cleared at writeback. Decode uses it for RAW hazard stalls.
- Sits between the ID stage (reads, issue) and the WB stage (write).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_sb_if.sv | 31 +++
 rtl/rf_scoreboard.sv | 65 ++++++
 rtl/regfile_sb.sv | 75 +++++++
 tb/tb_regfile_sb.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned REG_ZERO       = 0;

    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Register file bus: ID-stage reads and issue, WB-stage writeback, flush and busy count.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD = 2
);

    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_dest;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output raddr, we, waddr, wdata, issue_valid, issue_dest, flush,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  raddr, we, waddr, wdata, issue_valid, issue_dest, flush,
        output rdata, rbusy, busy_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, wiped by flush,
// with a registered popcount of the busy vector.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned  ADDR_W   = DEFAULT_ADDR_W,
    parameter bit           ZERO_REG = 1'b1,
    localparam int unsigned Depth    = rf_depth(ADDR_W),
    localparam int unsigned CntW     = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_dest_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              flush_i,
    output logic [Depth-1:0]  busy_o,
    output logic [CntW-1:0]   busy_cnt_o
);

    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

    logic [Depth-1:0] busy_q, busy_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (we_i) begin
                busy_d[waddr_i] = 1'b0;
            end
            // Applied after the clear: a newer producer outranks a same-cycle writeback.
            if (issue_valid_i) begin
                busy_d[issue_dest_i] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_d[ZeroAddr] = 1'b0;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            cnt_d = cnt_d + CntW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read-port register file with optional write bypass, optional
// hardwired zero register and a busy scoreboard for RAW hazard detection.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         resetn,
    regfile_sb_if.slave bus
);

    localparam int unsigned       Depth    = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] rf_q [Depth];
    logic [Depth-1:0]  busy;
    logic              wr_en;

    assign wr_en = bus.we && !(ZERO_REG && (bus.waddr == ZeroAddr));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en) begin
            rf_q[bus.waddr] <= bus.wdata;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i         (clk),
        .rst_ni        (resetn),
        .issue_valid_i (bus.issue_valid),
        .issue_dest_i  (bus.issue_dest),
        .we_i          (bus.we),
        .waddr_i       (bus.waddr),
        .flush_i       (bus.flush),
        .busy_o        (busy),
        .busy_cnt_o    (bus.busy_cnt)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rb;

        assign ra = bus.raddr[p*ADDR_W +: ADDR_W];

        // A bypassed value is current, so the port reports it as not busy.
        always_comb begin
            rd = rf_q[ra];
            rb = busy[ra];
            if (ZERO_REG && (ra == ZeroAddr)) begin
                rd = '0;
                rb = 1'b0;
            end else if (BYPASS && bus.we && (bus.waddr == ra)) begin
                rd = bus.wdata;
                rb = 1'b0;
            end
        end

        assign bus.rdata[p*DATA_W +: DATA_W] = rd;
        assign bus.rbusy[p]                  = rb;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, corner-case sequences,
// a narrow 4-port configuration and randomized traffic against a behavioural model.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_b ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) bus_c ();

    regfile_sb #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) u_dut (
        .clk(clk), .resetn(resetn), .bus(bus_a)
    );

    regfile_sb #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) u_nobyp (
        .clk(clk), .resetn(resetn), .bus(bus_b)
    );

    regfile_sb #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(4), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) u_narrow (
        .clk(clk), .resetn(resetn), .bus(bus_c)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  idest;
        logic        flush;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        rb0;
        logic        rb1;
        logic [5:0]  cnt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic [31:0] m_rf   [32];
    bit          m_busy [32];

    function automatic vec_t mk(
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic iv, input logic [4:0] id, input logic fl,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic b0, input logic b1, input logic [5:0] cnt);
        vec_t v;
        v.we = we; v.waddr = wa; v.wdata = wd; v.iv = iv; v.idest = id; v.flush = fl;
        v.ra0 = r0; v.ra1 = r1; v.rd0 = d0; v.rd1 = d1; v.rb0 = b0; v.rb1 = b1;
        v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [15:0] sw_val(input int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic iv, input logic [4:0] id, input logic fl,
        input logic [4:0] r0, input logic [4:0] r1);
        bus_a.we = we; bus_a.waddr = wa; bus_a.wdata = wd;
        bus_a.issue_valid = iv; bus_a.issue_dest = id; bus_a.flush = fl;
        bus_a.raddr = {r1, r0};
    endtask

    task automatic idle_a(input logic [4:0] r0, input logic [4:0] r1);
        drive_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, r0, r1);
    endtask

    task automatic model_read(input logic [4:0] a, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, output logic [31:0] ed, output logic eb);
        if (a == 5'd0) begin
            ed = 32'd0; eb = 1'b0;
        end else if (we && wa == a) begin
            ed = wd; eb = 1'b0;
        end else begin
            ed = m_rf[a]; eb = m_busy[a];
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic run_random(input int n);
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 32'd0;
            m_busy[r] = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            logic        we, iv, fl, eb0, eb1;
            logic [4:0]  wa, id, r0, r1;
            logic [31:0] wd, ed0, ed1;
            int          cnt;
            we = 1'($urandom_range(0, 1));
            iv = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 15) == 0);
            wa = rnd_addr(); id = rnd_addr(); r0 = rnd_addr(); r1 = rnd_addr();
            wd = $urandom;
            drive_a(we, wa, wd, iv, id, fl, r0, r1);
            #1;
            model_read(r0, we, wa, wd, ed0, eb0);
            model_read(r1, we, wa, wd, ed1, eb1);
            check($sformatf("rand%0d rdata0", c), 64'(bus_a.rdata[31:0]), 64'(ed0));
            check($sformatf("rand%0d rdata1", c), 64'(bus_a.rdata[63:32]), 64'(ed1));
            check($sformatf("rand%0d rbusy0", c), 64'(bus_a.rbusy[0]), 64'(eb0));
            check($sformatf("rand%0d rbusy1", c), 64'(bus_a.rbusy[1]), 64'(eb1));
            if (we && wa != 5'd0) m_rf[wa] = wd;
            cnt = 0;
            for (int r = 1; r < 32; r++) begin
                if (fl)                           m_busy[r] = 1'b0;
                else if (iv && int'(id) == r)     m_busy[r] = 1'b1;
                else if (we && int'(wa) == r)     m_busy[r] = 1'b0;
                if (m_busy[r]) cnt++;
            end
            step();
            check($sformatf("rand%0d busy_cnt", c), 64'(bus_a.busy_cnt), 64'(cnt));
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6,
                      32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 6'd0);
        vecs[1]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd5, 5'd3,
                      32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 6'd1);
        vecs[2]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3,
                      32'h0, 32'h0, 1'b1, 1'b1, 6'd1);
        vecs[3]  = mk(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd3, 5'd5,
                      32'hA5, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
        vecs[4]  = mk(1'b1, 5'd9, 32'h11111111, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0,
                      32'h11111111, 32'h0, 1'b0, 1'b0, 6'd1);
        vecs[5]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd3,
                      32'h11111111, 32'hA5, 1'b1, 1'b0, 6'd1);
        vecs[6]  = mk(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd9,
                      32'h0, 32'h11111111, 1'b0, 1'b1, 6'd1);
        vecs[7]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0,
                      32'h0, 32'h0, 1'b0, 1'b0, 6'd1);
        vecs[8]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd9,
                      32'h0, 32'h11111111, 1'b0, 1'b1, 6'd2);
        vecs[9]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd31,
                      32'h0, 32'h0, 1'b1, 1'b0, 6'd2);
        vecs[10] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd12,
                      32'h0, 32'h0, 1'b0, 1'b1, 6'd0);
        vecs[11] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd12,
                      32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        vecs[12] = mk(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd20, 5'd7,
                      32'h0, 32'h12345678, 1'b0, 1'b0, 6'd0);
        vecs[13] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd9,
                      32'h12345678, 32'h11111111, 1'b0, 1'b0, 6'd0);

        resetn = 1'b1;
        idle_a(5'd5, 5'd6);
        bus_b.we = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.issue_valid = 1'b0;
        bus_b.issue_dest = '0; bus_b.flush = 1'b0; bus_b.raddr = '0;
        bus_c.we = 1'b0; bus_c.waddr = '0; bus_c.wdata = '0; bus_c.issue_valid = 1'b0;
        bus_c.issue_dest = '0; bus_c.flush = 1'b0; bus_c.raddr = '0;
        #2 resetn = 1'b0;
        #1;
        check("reset rdata0", 64'(bus_a.rdata[31:0]), 64'h0);
        check("reset rbusy", 64'(bus_a.rbusy), 64'h0);
        check("reset busy_cnt", 64'(bus_a.busy_cnt), 64'h0);
        #19 resetn = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            drive_a(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].iv, vecs[i].idest,
                    vecs[i].flush, vecs[i].ra0, vecs[i].ra1);
            #1;
            check($sformatf("vec%0d rdata0", i), 64'(bus_a.rdata[31:0]), 64'(vecs[i].rd0));
            check($sformatf("vec%0d rdata1", i), 64'(bus_a.rdata[63:32]), 64'(vecs[i].rd1));
            check($sformatf("vec%0d rbusy0", i), 64'(bus_a.rbusy[0]), 64'(vecs[i].rb0));
            check($sformatf("vec%0d rbusy1", i), 64'(bus_a.rbusy[1]), 64'(vecs[i].rb1));
            step();
            check($sformatf("vec%0d busy_cnt", i), 64'(bus_a.busy_cnt), 64'(vecs[i].cnt));
        end

        // Asynchronous reset between edges.
        drive_a(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 1'b0, 5'd5, 5'd6);
        step();
        idle_a(5'd5, 5'd6);
        #1;
        check("prereset rdata0", 64'(bus_a.rdata[31:0]), 64'hDEADBEEF);
        check("prereset rbusy1", 64'(bus_a.rbusy[1]), 64'h1);
        #2 resetn = 1'b0;
        #1;
        check("async reset rdata0", 64'(bus_a.rdata[31:0]), 64'h0);
        check("async reset rbusy1", 64'(bus_a.rbusy[1]), 64'h0);
        check("async reset busy_cnt", 64'(bus_a.busy_cnt), 64'h0);
        #1 resetn = 1'b1;
        #1;
        check("post release rdata0", 64'(bus_a.rdata[31:0]), 64'h0);
        step();
        check("first edge rdata0", 64'(bus_a.rdata[31:0]), 64'h0);
        check("first edge busy_cnt", 64'(bus_a.busy_cnt), 64'h0);

        // Scoreboard lifecycle on r3.
        drive_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        #1;
        check("life N rbusy", 64'(bus_a.rbusy[0]), 64'h0);
        step();
        idle_a(5'd3, 5'd0);
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("life N+%0d rbusy", k), 64'(bus_a.rbusy[0]), 64'h1);
            check($sformatf("life N+%0d busy_cnt", k), 64'(bus_a.busy_cnt), 64'h1);
            step();
        end
        drive_a(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
        #1;
        check("life N+4 rbusy", 64'(bus_a.rbusy[0]), 64'h0);
        check("life N+4 rdata", 64'(bus_a.rdata[31:0]), 64'hA5);
        step();
        idle_a(5'd3, 5'd0);
        #1;
        check("life N+5 busy_cnt", 64'(bus_a.busy_cnt), 64'h0);
        check("life N+5 rdata", 64'(bus_a.rdata[31:0]), 64'hA5);

        // No-bypass configuration: old value and busy flag visible until the edge.
        bus_b.we = 1'b1; bus_b.waddr = 5'd7; bus_b.wdata = 32'h0BADF00D;
        bus_b.issue_valid = 1'b1; bus_b.issue_dest = 5'd7;
        step();
        bus_b.issue_valid = 1'b0; bus_b.wdata = 32'h12345678; bus_b.raddr = {5'd7, 5'd0};
        #1;
        check("nobyp rdata1 before", 64'(bus_b.rdata[63:32]), 64'h0BADF00D);
        check("nobyp rbusy1 before", 64'(bus_b.rbusy[1]), 64'h1);
        step();
        bus_b.we = 1'b0;
        #1;
        check("nobyp rdata1 after", 64'(bus_b.rdata[63:32]), 64'h12345678);
        check("nobyp rbusy1 after", 64'(bus_b.rbusy[1]), 64'h0);

        // Narrow four-port configuration.
        for (int i = 1; i < 8; i++) begin
            bus_c.we = 1'b1; bus_c.waddr = 3'(i); bus_c.wdata = sw_val(i);
            step();
        end
        bus_c.we = 1'b0;
        for (int s = 0; s < 2; s++) begin
            logic [2:0] a [4];
            for (int p = 0; p < 4; p++) begin
                a[p] = (s == 0) ? 3'(2 * p + 1) : 3'((2 * p + 2) % 8);
                bus_c.raddr[p*3 +: 3] = a[p];
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                check($sformatf("narrow set%0d port%0d", s, p),
                      64'(bus_c.rdata[p*16 +: 16]),
                      (a[p] == 3'd0) ? 64'h0 : 64'(sw_val(int'(a[p]))));
            end
            step();
        end
        for (int i = 1; i < 8; i++) begin
            bus_c.issue_valid = 1'b1; bus_c.issue_dest = 3'(i);
            step();
            check($sformatf("narrow issue%0d busy_cnt", i), 64'(bus_c.busy_cnt), 64'(i));
        end
        bus_c.issue_valid = 1'b0;
        bus_c.raddr = {3'd4, 3'd0, 3'd7, 3'd1};
        #1;
        check("narrow rbusy", 64'(bus_c.rbusy), 64'b1011);

        // Randomized traffic from a fresh reset.
        resetn = 1'b0;
        #2 resetn = 1'b1;
        step();
        run_random(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
